// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and constants for the instruction-fetch PC sequencer.
package pc_sequencer_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = '0;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: execute redirect, instruction-memory and decode handshakes of the fetch sequencer.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            misalign;
    modport master (
        input  br_taken, br_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, misalign
    );
    modport slave (
        output br_taken, br_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, misalign
    );
endinterface

// File: rtl/pc_sequencer_pc_next_sel.sv
// pc_next_sel: next-pc select (hold / pc+4 / aligned target) with alignment check.
// PC_MISALIGN_TRAP_EN: misaligned targets flag a fault and hold pc; otherwise the low bits are forced to zero.
module pc_next_sel
    import pc_sequencer_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            br_taken_i,
    input  logic            inc_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            misalign_o
);
    logic [XLEN-1:0] tgt;
    assign tgt = br_target_i & ~XLEN'(INSTR_BYTES - 1);
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o = br_taken_i & (br_target_i != tgt);
`else
    assign misalign_o = 1'b0;
`endif
    assign pc_next_o = misalign_o ? pc_i : br_taken_i ? tgt : inc_i ? pc_i + XLEN'(INSTR_BYTES) : pc_i;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: single-outstanding instruction fetch with redirect, wrong-path drop and decode buffer.
// PC_MISALIGN_TRAP_EN enables the sticky misalign fault (see pc_next_sel).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.master bus
);
    state_e          state_q;
    logic [XLEN-1:0] pc_q, pc_d, if_pc_q;
    logic [31:0]     if_instr_q;
    logic            drop_q, misalign_q, br, inc, bad;

    assign br  = bus.br_taken & (state_q != FAULT);
    assign inc = (state_q == WAIT) & bus.imem_rsp_valid & ~drop_q;

    pc_next_sel u_sel (
        .pc_i        (pc_q),
        .br_target_i (bus.br_target),
        .br_taken_i  (br),
        .inc_i       (inc),
        .pc_next_o   (pc_d),
        .misalign_o  (bad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            drop_q     <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: if (bus.imem_req_ready) begin
                    state_q <= WAIT;
                    drop_q  <= br;
                end
                // a redirect coinciding with the response kills it outright, so drop never needs setting
                WAIT: if (bus.imem_rsp_valid) begin
                    drop_q  <= 1'b0;
                    state_q <= (inc && !br) ? HOLD : REQ;
                    if (inc && !br) begin
                        if_instr_q <= bus.imem_rsp_data;
                        if_pc_q    <= pc_q;
                    end
                end else if (br) drop_q <= 1'b1;
                HOLD: if (br) begin
                    state_q    <= REQ;
                    if_instr_q <= '0;
                    if_pc_q    <= '0;
                end else if (bus.if_ready) state_q <= REQ;
                default: state_q <= FAULT;
            endcase
            if (bad) begin
                misalign_q <= 1'b1;
                state_q    <= FAULT;
            end
        end
    end

    assign bus.imem_req_valid = state_q == REQ;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = state_q == HOLD;
    assign bus.if_instr       = if_instr_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.misalign       = misalign_q;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch program counter sequencer for the RISC-V core. It consumes the branch decision and the branch target address produced in execute, and issues one instruction-memory request at a time. It discards wrong-path responses after a redirect and presents each fetched instruction, with its PC, to decode over a valid/ready handshake.

## Interface
- XLEN, 32, address/data width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.

- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- br_taken  in  1  single-cycle redirect request from execute.
- br_target  in  XLEN  redirect address, sampled when br_taken=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  fetch address; equals pc.
- imem_rsp_valid  in  1  response data valid, at least one cycle after acceptance.
- imem_rsp_data  in  32  fetched instruction word.
- if_valid  out  1  fetched instruction available to decode.
- if_ready  in  1  decode accepts the instruction.
- if_instr  out  32  instruction word.
- if_pc  out  XLEN  address of if_instr.
- misalign  out  1  sticky misaligned-target fault; see Configuration.

## Operation
- Registers: pc, the state, the drop flag, and the instruction buffer (if_instr, if_pc).
- At most one request is outstanding. A response always belongs to the last accepted request.
- IDLE: entered on reset; moves to REQ on the next clock edge.
- REQ: imem_req_valid=1 and imem_req_addr=pc. On imem_req_valid & imem_req_ready, go to WAIT.
- WAIT: on imem_rsp_valid with drop=0, capture if_instr<=imem_rsp_data and if_pc<=pc, set pc<=pc+4, then go to HOLD. On imem_rsp_valid with drop=1, discard the data, clear drop, then go to REQ.
- HOLD: if_valid=1. On if_valid & if_ready, go to REQ.
- Redirect: br_taken has priority over every other pc update. Its effect depends on the state:
  - REQ without ready: pc<=br_target, stay in REQ. The address changes next cycle, and the memory must tolerate this.
  - REQ with ready in the same cycle: the accepted request is wrong-path. Set pc<=br_target and drop<=1, then go to WAIT.
  - WAIT: pc<=br_target and drop<=1. If imem_rsp_valid is high in the same cycle, discard that response, keep drop=0, and go to REQ.
  - HOLD: pc<=br_target and clear the buffer. if_valid=0 next cycle, even if if_ready is high. Go to REQ.
  - IDLE: pc<=br_target.
- pc+4 arithmetic wraps modulo 2^XLEN; there is no overflow detection.

## Timing
- Reset values: pc=RESET_VECTOR, state=IDLE, drop=0, imem_req_valid=0, imem_req_addr=RESET_VECTOR, if_valid=0, if_instr=0, if_pc=0, misalign=0.
- First imem_req_valid is asserted in the second cycle after reset deasserts.
- Throughput is at most one instruction per 3 cycles with zero-wait memory: REQ, then WAIT, then HOLD.
- Latency from acceptance to if_valid is the response latency plus 1 cycle.
- When reset asserts in any state, all outputs take their reset values asynchronously. Any in-flight response arriving after reset is ignored, because the sequencer is then in IDLE or REQ.
- if_instr and if_pc are stable while if_valid=1 and if_ready=0.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - br_taken with br_target[1:0]!=2'b00 sets misalign=1 (sticky) and leaves pc unchanged.
  - The sequencer enters a FAULT state: imem_req_valid=0 and if_valid=0 until reset.
  - An outstanding response in flight is discarded.
- PC_MISALIGN_TRAP_EN undefined:
  - br_target[1:0] is forced to 2'b00 before use.
  - misalign is tied to 0 and there is no FAULT state.

## Structure
- The shared package holds the state enum (IDLE, REQ, WAIT, HOLD, FAULT), XLEN, INSTR_BYTES=4, and RESET_VECTOR_DEFAULT.
- One combinational sub-module is natural: pc_next_sel. It selects the next pc from the options hold / pc+4 / aligned br_target, and applies the alignment check.

## Test plan
- Reset release, memory always ready with a 1-cycle response: addresses 0x0, 0x4, 0x8 are fetched. if_pc matches each address, with one instruction every 3 cycles.
- imem_req_ready held low for 4 cycles in REQ: imem_req_addr stays 0x0 and is stable. Acceptance occurs on the fifth cycle.
- br_taken with target 0x100 while in WAIT for the request to 0x8: the 0x8 response is discarded with no if_valid. The next request is 0x100, and if_pc=0x100.
- br_taken with target 0x200 in the same cycle as imem_rsp_valid: that response is dropped, and the next request goes to 0x200.
- HOLD with if_ready=0 for 5 cycles, then br_taken to 0x40: if_valid is 0 next cycle and the next request goes to 0x40.
- Target 0x102 with PC_MISALIGN_TRAP_EN defined: misalign=1, no further requests, and it stays this way until reset. With the macro undefined: the fetch goes to 0x100.
